branch_resolve_unit: RTL

ID-stage branch/jump resolver sitting directly downstream of the branch forwarding unit. It consumes the 2-bit operand forward selects, muxes operands from register file or EX/MEM/WB results, and stalls ID while a selected producer is a load whose data is not yet available. Once operands are ready, it evaluates the RV32I branch condition and target, then issues a registered one-cycle redirect plus IF/ID flush. It also keeps free-running resolution statistics.

---
 rtl/branch_resolve_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch/jump resolver.
// Selects forwarded operands, stalls ID while a selected producer is a load
// whose data is not yet available, evaluates RV32I branch/jump outcomes, and
// issues a registered one-cycle redirect plus IF/ID flush. Free-running
// statistics counters track evaluations, taken outcomes and stall cycles.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_branch,
  input  logic             i_jal,
  input  logic             i_jalr,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [1:0]       i_forward_a,
  input  logic [1:0]       i_forward_b,
  input  logic [XLEN-1:0]  i_ex_result,
  input  logic [XLEN-1:0]  i_mem_result,
  input  logic [XLEN-1:0]  i_wb_result,
  input  logic             i_ex_mem_read,
  input  logic             i_mem_mem_read,
  output logic             o_stall,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_branch_count,
  output logic [CNT_W-1:0] o_taken_count,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    S_RESOLVE = 2'b00,
    S_STALL   = 2'b01,
    S_SHADOW  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_redirect;
  logic [XLEN-1:0]   r_redirect_pc;
  logic [CNT_W-1:0]  r_branch_count;
  logic [CNT_W-1:0]  r_taken_count;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic              w_cf;
  logic              w_use_a;
  logic              w_use_b;
  logic              w_hazard;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_op_b;
  logic              w_br_taken;
  logic              w_taken;
  logic [XLEN-1:0]   w_sum_pc;
  logic [XLEN-1:0]   w_sum_a;
  logic [XLEN-1:0]   w_target;
  logic              w_stall;
  logic              w_eval;

  // A producer selected through EX or MEM is unusable while it is a load.
  function automatic logic f_load_hazard(input logic [1:0] sel,
                                         input logic       ex_ld,
                                         input logic       mem_ld);
    return ((sel == 2'b01) && ex_ld) || ((sel == 2'b10) && mem_ld);
  endfunction

  assign w_cf     = i_valid && (i_branch || i_jal || i_jalr);
  assign w_use_a  = i_branch || i_jalr;
  assign w_use_b  = i_branch;
  assign w_hazard = (w_use_a && f_load_hazard(i_forward_a, i_ex_mem_read, i_mem_mem_read)) ||
                    (w_use_b && f_load_hazard(i_forward_b, i_ex_mem_read, i_mem_mem_read));

  // Operand A source mux driven by the forwarding unit select.
  always_comb begin
    w_op_a = i_rs1_data;
    case (i_forward_a)
      2'b00:   w_op_a = i_rs1_data;
      2'b01:   w_op_a = i_ex_result;
      2'b10:   w_op_a = i_mem_result;
      2'b11:   w_op_a = i_wb_result;
      default: w_op_a = i_rs1_data;
    endcase
  end

  // Operand B source mux driven by the forwarding unit select.
  always_comb begin
    w_op_b = i_rs2_data;
    case (i_forward_b)
      2'b00:   w_op_b = i_rs2_data;
      2'b01:   w_op_b = i_ex_result;
      2'b10:   w_op_b = i_mem_result;
      2'b11:   w_op_b = i_wb_result;
      default: w_op_b = i_rs2_data;
    endcase
  end

  // RV32I branch condition; reserved funct3 encodings resolve not-taken.
  always_comb begin
    w_br_taken = 1'b0;
    case (i_funct3)
      3'b000:  w_br_taken = (w_op_a == w_op_b);
      3'b001:  w_br_taken = (w_op_a != w_op_b);
      3'b100:  w_br_taken = ($signed(w_op_a) <  $signed(w_op_b));
      3'b101:  w_br_taken = ($signed(w_op_a) >= $signed(w_op_b));
      3'b110:  w_br_taken = (w_op_a <  w_op_b);
      3'b111:  w_br_taken = (w_op_a >= w_op_b);
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_taken  = i_jal || i_jalr || (i_branch && w_br_taken);
  assign w_sum_pc = i_pc + i_imm;
  assign w_sum_a  = w_op_a + i_imm;
  assign w_target = i_jalr ? {w_sum_a[XLEN-1:1], 1'b0} : w_sum_pc;

  // Next-state, stall and evaluate decisions; SHADOW ignores wrong-path ID.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_eval       = 1'b0;
    case (r_state)
      S_RESOLVE: begin
        if (w_cf && w_hazard) begin
          w_stall      = 1'b1;
          w_next_state = S_STALL;
        end else if (w_cf) begin
          w_eval       = 1'b1;
          w_next_state = w_taken ? S_SHADOW : S_RESOLVE;
        end else begin
          w_next_state = S_RESOLVE;
        end
      end
      S_STALL: begin
        if (!w_cf) begin
          w_next_state = S_RESOLVE;
        end else if (w_hazard) begin
          w_stall      = 1'b1;
          w_next_state = S_STALL;
        end else begin
          w_eval       = 1'b1;
          w_next_state = w_taken ? S_SHADOW : S_RESOLVE;
        end
      end
      S_SHADOW: begin
        w_next_state = S_RESOLVE;
      end
      default: begin
        w_next_state = S_RESOLVE;
      end
    endcase
  end

  // Stall is held low while reset is asserted regardless of inputs.
  assign o_stall = w_stall && i_rst_n;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RESOLVE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // One-cycle redirect pulse; target only reloads on a taken evaluation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= {XLEN{1'b0}};
    end else begin
      r_redirect <= w_eval && w_taken;
      if (w_eval && w_taken) begin
        r_redirect_pc <= w_target;
      end
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_count <= {CNT_W{1'b0}};
      r_taken_count  <= {CNT_W{1'b0}};
      r_stall_cycles <= {CNT_W{1'b0}};
    end else begin
      if (w_eval) begin
        r_branch_count <= r_branch_count + CNT_W'(1);
      end
      if (w_eval && w_taken) begin
        r_taken_count <= r_taken_count + CNT_W'(1);
      end
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign o_redirect     = r_redirect;
  assign o_flush        = r_redirect;
  assign o_redirect_pc  = r_redirect_pc;
  assign o_branch_count = r_branch_count;
  assign o_taken_count  = r_taken_count;
  assign o_stall_cycles = r_stall_cycles;

endmodule
